clock_time_ctrl: RTL and testbench
==================================

# clock_time_ctrl

Timekeeping and set-mode controller for the 7-segment clock display. Keeps hours, minutes and seconds from a free-running prescaler and runs a three-state FSM (run / set hour / set minute) driven by two debounced button pulses. Drives the `houres` and `minute` inputs of the display top and supplies per-field blank flags so the scanner can flash the field being edited.

## Interface

Parameters:
- `TICKS_PER_SEC`, default 50_000_000: clk cycles per second, minimum 2.
- `BLINK_TICKS`, default 12_500_000: clk cycles per blink half-period, minimum 1.

Ports (clock and reset first):
- `clk` in 1: system clock. This is the block's only clock.
- `reset` in 1: synchronous, active-high reset.
- `btn_mode` in 1: single-cycle pulse that advances the mode. Debounced upstream.
- `btn_inc` in 1: single-cycle pulse that increments the selected field. Debounced upstream.
- `houres` out 9: hours, binary 0..23, zero-extended.
- `minute` out 6: minutes, binary 0..59.
- `second` out 6: seconds, binary 0..59.
- `sec_tick` out 1: one-cycle pulse when `second` advances.
- `mode` out 2: current state. 0=RUN, 1=SET_HOUR, 2=SET_MIN. Encoding 3 is never produced.
- `blank_hour` out 1: blank the hour digits in this cycle.
- `blank_min` out 1: blank the minute digits in this cycle.

## Operation

- All outputs are registered.
- Reset values:
  - `houres`=0, `minute`=0, `second`=0.
  - `sec_tick`=0, `mode`=RUN.
  - `blank_hour`=0, `blank_min`=0.
  - Prescaler=0, blink counter=0, blink phase=0.
- Reset asserted mid-operation, in any state, returns the block to these values on the next edge.

RUN state:
- Prescaler counts 0..TICKS_PER_SEC-1 and wraps to 0.
- On the edge where the prescaler equals TICKS_PER_SEC-1:
  - `second` increments and `sec_tick`=1 for the following cycle.
  - 59 wraps to 0 and carries into `minute` on the same edge.
  - `minute` 59 wraps to 0 and carries into `houres`.
  - `houres` 23 wraps to 0.
  - 23:59:59 goes to 00:00:00 in one edge.
- `btn_inc` is ignored.

SET_HOUR state:
- Prescaler is held at 0 and `second` is frozen. `sec_tick` stays 0.
- `btn_inc` increments `houres`; 23 wraps to 0. There is no carry.

SET_MIN state:
- Same as SET_HOUR, except `btn_inc` increments `minute`; 59 wraps to 0. There is no carry into `houres`.

Mode transitions, each on a `btn_mode` pulse:
- RUN to SET_HOUR.
- SET_HOUR to SET_MIN.
- SET_MIN to RUN. On this edge `second` and the prescaler clear to 0, so the first tick arrives TICKS_PER_SEC cycles later.

Simultaneous events:
- `btn_mode` and `btn_inc` in the same cycle: the mode change wins and the increment is dropped.
- `btn_mode` in RUN on the same edge as the terminal prescaler count: the mode change wins. The second-increment is dropped, the prescaler goes to 0 and `sec_tick` stays 0.
- Button pulses longer than one cycle act once per asserted cycle; upstream guarantees single-cycle pulses.

Blink:
- In RUN, the blink counter and phase are held at 0 and both blank flags are 0.
- In a SET state, the blink counter counts 0..BLINK_TICKS-1 and the phase toggles on wrap.
- `blank_hour` = phase AND SET_HOUR. `blank_min` = phase AND SET_MIN.
- Any `btn_inc` or `btn_mode` pulse clears the counter and the phase, so an edited field is shown immediately.

## Timing

- Latency is one cycle from button pulse to the updated `mode` or field output.
- `sec_tick` rises in the same cycle that the new `second` value is visible. It stays high exactly one cycle.
- In RUN, the tick period is exactly TICKS_PER_SEC cycles.
- Blank flags change one cycle after the blink counter wraps.
- There are no combinational paths from inputs to outputs.

## Test plan

All scenarios use TICKS_PER_SEC=4 and BLINK_TICKS=2.

- **Reset:** assert `reset` for 2 cycles, then release -> all outputs 0 and `mode`=0. The first `sec_tick` appears in the 4th cycle after release with `second`=1. `sec_tick` is then high every 4 cycles.
- **Full rollover:** preset 23:59:58 via set mode, then run 8 cycles -> 23:59:59, then 00:00:00. `sec_tick` pulses twice.
- **Set sequence:**
  - Apply `btn_mode` -> `mode`=1.
  - Apply 25 `btn_inc` pulses -> `houres`=1.
  - Apply `btn_mode` -> `mode`=2.
  - Apply 61 `btn_inc` pulses -> `minute`=1, and `houres` stays 1.
  - Apply `btn_mode` -> `mode`=0 and `second`=0. The next `sec_tick` comes exactly 4 cycles later.
- **Collisions:**
  - `btn_mode` and `btn_inc` in the same cycle in SET_HOUR -> `mode`=2 and `houres` unchanged.
  - `btn_mode` on the terminal prescaler cycle in RUN -> `mode`=1, `second` unchanged, no `sec_tick`.
- **Blink:**
  - In SET_HOUR with no buttons pressed -> `blank_hour` toggles every 2 cycles and `blank_min`=0.
  - A `btn_inc` while `blank_hour`=1 -> `blank_hour`=0 next cycle.
  - In RUN -> both blank flags stay 0.
- **Reset mid-edit:** assert `reset` in SET_MIN at 05:07:xx -> next cycle `mode`=0, time 00:00:00, blank flags 0.

Source files
------------

// File: rtl/clock_time_ctrl_if.sv
// Button inputs and display-side outputs of the clock timekeeping controller.
// The master drives the buttons; the slave (the controller) drives time, mode and blank flags.
interface clock_time_ctrl_if;
  logic       btn_mode;
  logic       btn_inc;
  logic [8:0] houres;
  logic [5:0] minute;
  logic [5:0] second;
  logic       sec_tick;
  logic [1:0] mode;
  logic       blank_hour;
  logic       blank_min;

  modport master (
    output btn_mode, btn_inc,
    input  houres, minute, second, sec_tick, mode, blank_hour, blank_min
  );

  modport slave (
    input  btn_mode, btn_inc,
    output houres, minute, second, sec_tick, mode, blank_hour, blank_min
  );
endinterface

// File: rtl/clock_time_ctrl.sv
// Timekeeping and run/set-hour/set-minute controller for the 7-segment clock.
// Keeps hh:mm:ss from a prescaler and produces blink flags for the field under edit.
module clock_time_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned BLINK_TICKS   = 12_500_000
) (
  input  logic             clk,
  input  logic             reset,
  clock_time_ctrl_if.slave bus
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam int unsigned BW = $clog2(BLINK_TICKS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          tick_q, tick_d;
  logic          blank_hour_q, blank_min_q;

  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    tick_d      = 1'b0;

    case (state_q)
      RUN: begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        // A mode press on the terminal prescaler count swallows that second.
        if (bus.btn_mode) begin
          state_d = SET_HOUR;
          presc_d = '0;
        end else if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
          if (sec_q == 6'd59) begin
            sec_d = '0;
            if (min_q == 6'd59) begin
              min_d  = '0;
              hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      SET_HOUR: begin
        presc_d = '0;
        if (bus.btn_mode) begin
          state_d = SET_MIN;
        end else if (bus.btn_inc) begin
          hour_d = (hour_q == 5'd23) ? '0 : hour_q + 5'd1;
        end
      end

      SET_MIN: begin
        presc_d = '0;
        if (bus.btn_mode) begin
          state_d = RUN;
          sec_d   = '0;
        end else if (bus.btn_inc) begin
          min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
        end
      end

      default: begin
        state_d = RUN;
        presc_d = '0;
      end
    endcase

    // Any button press restarts the blink so the edited field shows at once.
    if (state_q == SET_HOUR || state_q == SET_MIN) begin
      if (bus.btn_mode || bus.btn_inc) begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      presc_q      <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      hour_q       <= '0;
      min_q        <= '0;
      sec_q        <= '0;
      tick_q       <= 1'b0;
      blank_hour_q <= 1'b0;
      blank_min_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      hour_q       <= hour_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      tick_q       <= tick_d;
      blank_hour_q <= phase_d && (state_d == SET_HOUR);
      blank_min_q  <= phase_d && (state_d == SET_MIN);
    end
  end

  assign bus.houres     = {4'b0000, hour_q};
  assign bus.minute     = min_q;
  assign bus.second     = sec_q;
  assign bus.sec_tick   = tick_q;
  assign bus.mode       = state_q;
  assign bus.blank_hour = blank_hour_q;
  assign bus.blank_min  = blank_min_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Bench for clock_time_ctrl: time-of-day model in plain seconds, directed scenarios
// followed by randomized button/reset traffic, every output compared each cycle.
module tb_clock_time_ctrl;

  localparam int T = 4;
  localparam int B = 2;

  logic clk;
  logic reset;
  clock_time_ctrl_if bif ();

  clock_time_ctrl #(
    .TICKS_PER_SEC(T),
    .BLINK_TICKS  (B)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference: seconds-of-day, mode, cycles spent in RUN and cycles since last blink restart.
  int m_tod   = 0;
  int m_mode  = 0;
  int m_run   = 0;
  int m_blink = 0;
  int m_tick  = 0;

  function automatic void check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endfunction

  always @(posedge clk) begin
    int h, m;
    m_tick = 0;
    if (reset) begin
      m_tod = 0; m_mode = 0; m_run = 0; m_blink = 0;
    end else begin
      case (m_mode)
        0: begin
          if (bif.btn_mode) begin
            m_mode = 1; m_run = 0; m_blink = 0;
          end else begin
            m_run++;
            if (m_run % T == 0) begin
              m_tod  = (m_tod + 1) % 86400;
              m_tick = 1;
            end
          end
        end
        1: begin
          if (bif.btn_mode) begin
            m_mode = 2; m_blink = 0;
          end else if (bif.btn_inc) begin
            h = m_tod / 3600;
            m_tod = ((h + 1) % 24) * 3600 + m_tod % 3600;
            m_blink = 0;
          end else m_blink++;
        end
        default: begin
          if (bif.btn_mode) begin
            m_mode = 0; m_tod = m_tod - m_tod % 60; m_run = 0; m_blink = 0;
          end else if (bif.btn_inc) begin
            m = (m_tod / 60) % 60;
            m_tod = m_tod - m * 60 + ((m + 1) % 60) * 60;
            m_blink = 0;
          end else m_blink++;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int ph;
      ph = (m_blink / B) % 2;
      check("houres",     int'(bif.houres),     m_tod / 3600);
      check("minute",     int'(bif.minute),     (m_tod / 60) % 60);
      check("second",     int'(bif.second),     m_tod % 60);
      check("sec_tick",   int'(bif.sec_tick),   m_tick);
      check("mode",       int'(bif.mode),       m_mode);
      check("blank_hour", int'(bif.blank_hour), (m_mode == 1 && ph == 1) ? 1 : 0);
      check("blank_min",  int'(bif.blank_min),  (m_mode == 2 && ph == 1) ? 1 : 0);
    end
  end

  task automatic cyc(input bit bm, input bit bi, input bit rst);
    @(negedge clk);
    bif.btn_mode = bm;
    bif.btn_inc  = bi;
    reset        = rst;
    @(posedge clk);
    #1;
    bif.btn_mode = 1'b0;
    bif.btn_inc  = 1'b0;
    reset        = 1'b0;
  endtask

  task automatic wait_tick(input string nm, input int exp_n);
    int n;
    n = -1;
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (bif.sec_tick) begin
        n = k;
        break;
      end
    end
    check(nm, n, exp_n);
  endtask

  // Enters SET_HOUR from RUN and leaves the block in SET_MIN at hh:mm.
  task automatic set_time(input int h, input int m);
    int ch, cm;
    cyc(1'b1, 1'b0, 1'b0);
    ch = m_tod / 3600;
    repeat ((h - ch + 24) % 24) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cm = (m_tod / 60) % 60;
    repeat ((m - cm + 60) % 60) cyc(1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    bif.btn_mode = 1'b0;
    bif.btn_inc  = 1'b0;
    reset        = 1'b1;

    // Reset and tick cadence
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    check("rst_houres", int'(bif.houres), 0);
    check("rst_minute", int'(bif.minute), 0);
    check("rst_second", int'(bif.second), 0);
    check("rst_mode",   int'(bif.mode),   0);
    check("rst_tick",   int'(bif.sec_tick), 0);
    wait_tick("first_tick_latency", 4);
    check("first_tick_second", int'(bif.second), 1);
    wait_tick("tick_period", 4);
    check("second_tick_second", int'(bif.second), 2);

    // Set sequence with wrap-around
    cyc(1'b1, 1'b0, 1'b0);
    check("set_mode1", int'(bif.mode), 1);
    repeat (25) cyc(1'b0, 1'b1, 1'b0);
    check("hour_wrap", int'(bif.houres), 1);
    cyc(1'b1, 1'b0, 1'b0);
    check("set_mode2", int'(bif.mode), 2);
    repeat (61) cyc(1'b0, 1'b1, 1'b0);
    check("min_wrap", int'(bif.minute), 1);
    check("min_no_carry", int'(bif.houres), 1);
    cyc(1'b1, 1'b0, 1'b0);
    check("back_to_run", int'(bif.mode), 0);
    check("second_cleared", int'(bif.second), 0);
    wait_tick("tick_after_set", 4);

    // Collision: mode+inc in SET_HOUR
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("coll_mode", int'(bif.mode), 2);
    check("coll_houres", int'(bif.houres), 1);
    cyc(1'b1, 1'b0, 1'b0);

    // Collision: mode on terminal prescaler count
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("term_mode", int'(bif.mode), 1);
    check("term_second", int'(bif.second), 0);
    check("term_tick", int'(bif.sec_tick), 0);

    // Blink in SET_HOUR, then restart by inc
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      check("blink_hour", int'(bif.blank_hour), (k / 2) % 2);
      check("blink_min_off", int'(bif.blank_min), 0);
    end
    cyc(1'b0, 1'b1, 1'b0);
    check("blink_restart", int'(bif.blank_hour), 0);
    check("inc_houres", int'(bif.houres), 2);
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      check("blink_min", int'(bif.blank_min), (k / 2) % 2);
    end
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      check("run_no_blank", int'(bif.blank_hour | bif.blank_min), 0);
    end

    // Full rollover from 23:59:58
    set_time(23, 59);
    cyc(1'b1, 1'b0, 1'b0);
    repeat (58 * T) cyc(1'b0, 1'b0, 1'b0);
    check("pre_h", int'(bif.houres), 23);
    check("pre_m", int'(bif.minute), 59);
    check("pre_s", int'(bif.second), 58);
    ticks = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (bif.sec_tick) ticks++;
      if (k == 4) check("roll_s59", int'(bif.second), 59);
    end
    check("roll_h", int'(bif.houres), 0);
    check("roll_m", int'(bif.minute), 0);
    check("roll_s", int'(bif.second), 0);
    check("roll_ticks", ticks, 2);

    // Reset in the middle of an edit
    set_time(5, 7);
    check("edit_h", int'(bif.houres), 5);
    check("edit_m", int'(bif.minute), 7);
    check("edit_mode", int'(bif.mode), 2);
    cyc(1'b0, 1'b0, 1'b1);
    check("midrst_mode", int'(bif.mode), 0);
    check("midrst_time", int'(bif.houres) + int'(bif.minute) + int'(bif.second), 0);
    check("midrst_blank", int'(bif.blank_hour | bif.blank_min), 0);

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 25, $urandom_range(0, 299) == 0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
